// File: rtl/traffic_pkg.sv
// Shared types for the traffic light controller and its
// emergency preemption front end.
package traffic_pkg;

  localparam int NUM_ROADS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef logic [1:0] road_t;

  localparam road_t ROAD_M1 = 2'd0;
  localparam road_t ROAD_M2 = 2'd1;
  localparam road_t ROAD_MT = 2'd2;
  localparam road_t ROAD_S  = 2'd3;

endpackage

// File: rtl/emergency_debounce.sv
// Per-road detector qualifier: saturating run-length counter,
// qual is high while the run has reached DEBOUNCE_CYCLES.
module emergency_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic qual_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          qual_q;

  always_comb begin
    cnt_d = '0;
    if (req_i) begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      qual_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      qual_q <= (cnt_d == CMAX);
    end
  end

  assign qual_o = qual_q;

endmodule

// File: rtl/emergency_preempt_ctrl.sv
// Emergency preemption: debounce, round-robin arbitration,
// bounded grant hold and a clearance gap between grants.
module emergency_preempt_ctrl
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD_CYCLES = 3,
  parameter int MAX_HOLD_CYCLES = 32,
  parameter int CLEAR_CYCLES    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_ROADS-1:0] req_raw,
  output logic                 emergency_vehicle,
  output road_t                emergency_road,
  output logic                 busy,
  output logic                 timeout,
  output logic [NUM_ROADS-1:0] lockout
);

  localparam int HW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam int CLW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [HW-1:0] HMIN = HW'(MIN_HOLD_CYCLES);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD_CYCLES);
  localparam logic [CLW-1:0] CLAST = CLW'(CLEAR_CYCLES - 1);

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [CLW-1:0]       clr_q, clr_d;
  road_t                last_q, last_d;
  road_t                road_q, road_d;
  logic                 ev_q, ev_d;
  logic                 busy_q, busy_d;
  logic                 to_q, to_d;
  logic [NUM_ROADS-1:0] lock_q, lock_d;

  logic [NUM_ROADS-1:0] qual;
  logic [NUM_ROADS-1:0] elig;
  logic                 win_found;
  road_t                win_road;
  road_t                cand;
  logic                 to_fire;

  for (genvar i = 0; i < NUM_ROADS; i++) begin : g_db
    emergency_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req_raw[i]),
      .qual_o(qual[i])
    );
  end

  assign elig = qual & ~lock_q;

  // Search starts just after the last winner so every road gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_road  = last_q;
    cand      = '0;
    for (int k = 1; k <= NUM_ROADS; k++) begin
      cand = last_q + road_t'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_road  = cand;
      end
    end
  end

  assign to_fire = (state_q == ST_GRANT) && (hold_q == HMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      clr_q   <= '0;
      last_q  <= ROAD_S;
      road_q  <= ROAD_M1;
      ev_q    <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      clr_q   <= clr_d;
      last_q  <= last_d;
      road_q  <= road_d;
      ev_q    <= ev_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          hold_d  = HW'(1);
        end
      end
      ST_GRANT: begin
        hold_d = hold_q + HW'(1);
        if (to_fire || (!qual[road_q] && hold_q >= HMIN)) begin
          state_d = ST_CLEAR;
          clr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_q == CLAST) begin
          state_d = ST_IDLE;
        end else begin
          clr_d = clr_q + CLW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lockout clears as soon as the road's raw input drops.
  always_comb begin
    ev_d   = (state_d == ST_GRANT);
    busy_d = (state_d != ST_IDLE);
    to_d   = to_fire;
    road_d = road_q;
    last_d = last_q;
    if (state_q == ST_IDLE && win_found) begin
      road_d = win_road;
      last_d = win_road;
    end
    lock_d = lock_q;
    if (to_fire) begin
      lock_d = lock_d | (NUM_ROADS'(1) << road_q);
    end
    lock_d = lock_d & req_raw;
  end

  assign emergency_vehicle = ev_q;
  assign emergency_road    = road_q;
  assign busy              = busy_q;
  assign timeout           = to_q;
  assign lockout           = lock_q;

endmodule

// File: doc/emergency_preempt_ctrl.md
# emergency_preempt_ctrl

Generates the emergency preemption request consumed by `TrafficLightController` on its `emergency_vehicle` / `emergency_road[1:0]` inputs. Four per-approach detector inputs are debounced and qualified. Round-robin arbitration then selects one road, and the block holds the request for a bounded time. A clearance gap is inserted before the next grant. The block sits between the field detector interface (inputs already synchronized to `clk`) and the light controller.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive high samples needed to qualify a detector input.
- `MIN_HOLD_CYCLES`, default 3: minimum cycles `emergency_vehicle` stays high per grant.
- `MAX_HOLD_CYCLES`, default 32: grant timeout; must be greater than `MIN_HOLD_CYCLES`.
- `CLEAR_CYCLES`, default 5: cycles of forced deassertion between grants; must be at least 1.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_raw` input 4: per-road detector inputs; bit i is road i. Already synchronous to `clk`.
- `emergency_vehicle` output 1: registered preemption request to the light controller.
- `emergency_road` output 2: registered index of the granted road.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `timeout` output 1: one-cycle pulse when a grant is terminated by `MAX_HOLD_CYCLES`.
- `lockout` output 4: per-road lockout flags set by a timeout.

## Operation
- **Debounce, per road:**
  - A saturating counter increments on each edge at which `req_raw[i]` is 1.
  - The counter clears to 0 on any edge at which `req_raw[i]` is 0.
  - `qual[i]` is registered and equals 1 while the counter equals `DEBOUNCE_CYCLES`.
- **Eligibility:** road i is eligible when `qual[i]` is 1 and `lockout[i]` is 0.
- **Arbitration:**
  - Round-robin pointer `last_road`, reset value 3.
  - The search order is `last_road+1`, `last_road+2`, ... modulo 4.
  - The first eligible road found wins.
- **FSM:**
  - **IDLE → GRANT** when any road is eligible.
    - `emergency_road` is loaded with the winner and `emergency_vehicle` is set to 1.
    - `last_road` is set to the winner and `hold_cnt` is set to 1.
  - **GRANT:** `hold_cnt` increments each cycle.
    - Go to CLEAR when `qual[g]` is 0 and `hold_cnt` ≥ `MIN_HOLD_CYCLES`.
    - Also go to CLEAR when `hold_cnt` equals `MAX_HOLD_CYCLES`. This is the timeout case: pulse `timeout` and set `lockout[g]`.
    - On entry to CLEAR, `emergency_vehicle` drops to 0.
  - **CLEAR:** count `CLEAR_CYCLES` cycles, then go to IDLE. Requests arriving during CLEAR keep debouncing but are not granted.
- **Lockout:** `lockout[i]` clears on the first edge at which `req_raw[i]` is 0. A road that is stuck high cannot monopolise the outputs.
- **emergency_road:** retains the last granted value outside GRANT. The consumer must ignore it while `emergency_vehicle` is 0.
- **Simultaneous events:**
  - A timeout and the release of `qual[g]` on the same cycle count as a timeout.
  - A new request for road g arriving during its own CLEAR is granted only after CLEAR, and only if no other road wins round-robin.
- **Reset:** asserting `rst_n` low at any time, including mid-GRANT, immediately forces the following values:
  - `emergency_vehicle`=0, `emergency_road`=0, `busy`=0, `timeout`=0, `lockout`=0.
  - All counters cleared, FSM in IDLE, `last_road`=3.

## Timing
- Take `req_raw[i]` high and first sampled at edge 1. Then:
  - `qual[i]` is 1 after edge `DEBOUNCE_CYCLES`.
  - `emergency_vehicle` is 1 after edge `DEBOUNCE_CYCLES`+1. With defaults this is a latency of 5 edges.
- Minimum high time of `emergency_vehicle` is `MIN_HOLD_CYCLES` cycles; maximum is `MAX_HOLD_CYCLES` cycles.
- Release: take `req_raw` low at edge k after the hold minimum is met. Then:
  - `qual` drops after edge k.
  - `emergency_vehicle` drops after edge k+1.
- Minimum gap between grants is `CLEAR_CYCLES`+1 cycles low: `CLEAR_CYCLES` cycles in CLEAR plus one cycle in IDLE.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- **Shared package `traffic_pkg`:**
  - state enum: `ST_IDLE`, `ST_GRANT`, `ST_CLEAR`.
  - `road_t` (2-bit) with constants `ROAD_M1`=0, `ROAD_M2`=1, `ROAD_MT`=2, `ROAD_S`=3, shared with `TrafficLightController`.
- **Sub-module `emergency_debounce`:** one counter plus `qual` register, parameterized by `DEBOUNCE_CYCLES`, instantiated four times.
- **Top level:** the arbiter and FSM live in `emergency_preempt_ctrl`.

## Test plan
- **Basic grant:** `req_raw`=0001 held for 20 cycles.
  - `emergency_vehicle` is 1 from edge 5, with `emergency_road`=0.
  - It drops 1 edge after `req_raw` goes low.
  - `busy` stays high for 5 further cycles.
- **Glitch rejection:** `req_raw[2]` high for 3 cycles, low for 1, high for 3 → `emergency_vehicle` never asserts.
- **Round-robin:** `req_raw`=1111 held throughout with `MAX_HOLD_CYCLES`=32.
  - Grants rotate road 0, 1, 2, 3 in order.
  - Each grant times out with a `timeout` pulse.
  - `lockout` accumulates to 1111, after which there are no further grants.
- **Minimum hold:** `req_raw[1]` high for 5 cycles, then low → `emergency_vehicle` is high for exactly 3 cycles with `emergency_road`=1.
- **Lockout release:** after a road 3 timeout, drop `req_raw[3]` for 1 cycle, then raise it again.
  - `lockout[3]` clears.
  - Road 3 is re-granted `DEBOUNCE_CYCLES`+1 edges after the re-raise.
- **Reset mid-grant:** pulse `rst_n` low for 3 ns during GRANT (road 2).
  - All outputs are 0 immediately.
  - After release, with `req_raw[2]` still high, road 2 is re-granted at edge 5.
